// File: rtl/mandelbrot_dispatch.sv
// mandelbrot_dispatch: raster-order pixel scheduler handing fixed-point coordinates to a round-robin pool of iterators
module mandelbrot_dispatch #(
   parameter int NUM_WORKERS = 4,
   parameter int H_PIXELS    = 640,
   parameter int V_PIXELS    = 480,
   parameter int PIX_W       = $clog2(H_PIXELS*V_PIXELS)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic signed [26:0]       init_x,
   input  logic signed [26:0]       init_y,
   input  logic signed [26:0]       x_incr,
   input  logic signed [26:0]       y_incr,
   input  logic [NUM_WORKERS-1:0]   worker_req,
   input  logic [NUM_WORKERS-1:0]   worker_done,
   output logic [NUM_WORKERS-1:0]   assign_valid,
   output logic signed [26:0]       assign_cr,
   output logic signed [26:0]       assign_ci,
   output logic [PIX_W-1:0]         assign_addr,
   output logic                     busy,
   output logic                     frame_done,
   output logic [31:0]              frame_cycles
);
   localparam int PW = NUM_WORKERS > 1 ? $clog2(NUM_WORKERS) : 1;
   localparam int CW = H_PIXELS > 1 ? $clog2(H_PIXELS) : 1;
   typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN} state_t;
   state_t state;
   logic [PW-1:0] rr_ptr, gidx;
   logic [PW:0] j;
   logic found;
   logic [NUM_WORKERS-1:0] mask, grant, inflight;
   logic [CW-1:0] col;
   logic [PIX_W-1:0] addr;
   logic signed [26:0] ix, dx, dy, cur_x, cur_y;

   // a worker granted last cycle may still show req, so it is masked out once
   always_comb begin
      mask = worker_req & ~assign_valid;
      gidx = '0;
      found = 1'b0;
      j = '0;
      for (int i = 0; i < NUM_WORKERS; i++) begin
         j = {1'b0, rr_ptr} + (PW+1)'(i);
         j = (j >= (PW+1)'(NUM_WORKERS)) ? j - (PW+1)'(NUM_WORKERS) : j;
         if (!found && mask[j[PW-1:0]]) begin
            gidx = j[PW-1:0];
            found = 1'b1;
         end
      end
      grant = (state == DISPATCH && found) ? (NUM_WORKERS)'(1) << gidx : '0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         rr_ptr <= '0;
         inflight <= '0;
         col <= '0;
         addr <= '0;
         ix <= '0;
         dx <= '0;
         dy <= '0;
         cur_x <= '0;
         cur_y <= '0;
         assign_valid <= '0;
         assign_cr <= '0;
         assign_ci <= '0;
         assign_addr <= '0;
         busy <= 1'b0;
         frame_done <= 1'b0;
         frame_cycles <= '0;
      end else begin
         // done pulses only retire workers that actually hold a pixel
         inflight <= (inflight & ~worker_done) | grant;
         assign_valid <= grant;
         if (state != IDLE) frame_cycles <= frame_cycles + 32'd1;
         case (state)
            IDLE: if (start) begin
               ix <= init_x;
               dx <= x_incr;
               dy <= y_incr;
               cur_x <= init_x;
               cur_y <= init_y;
               col <= '0;
               addr <= '0;
               inflight <= '0;
               frame_cycles <= '0;
               frame_done <= 1'b0;
               busy <= 1'b1;
               state <= DISPATCH;
            end
            DISPATCH: if (found) begin
               assign_cr <= cur_x;
               assign_ci <= cur_y;
               assign_addr <= addr;
               addr <= addr + 1'b1;
               rr_ptr <= (gidx == PW'(NUM_WORKERS-1)) ? '0 : gidx + 1'b1;
               col <= (col == CW'(H_PIXELS-1)) ? '0 : col + 1'b1;
               cur_x <= (col == CW'(H_PIXELS-1)) ? ix : cur_x + dx;
               cur_y <= (col == CW'(H_PIXELS-1)) ? cur_y + dy : cur_y;
               if (addr == PIX_W'(H_PIXELS*V_PIXELS-1)) state <= DRAIN;
            end
            default: if ((inflight & ~worker_done) == '0) begin
               busy <= 1'b0;
               frame_done <= 1'b1;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mandelbrot_dispatch.sv
// tb_mandelbrot_dispatch: randomized worker pool driving the dispatcher, checked against a
// pixel-index arithmetic model of grant order, coordinates and frame accounting.
module tb_mandelbrot_dispatch;
   localparam int N = 4, H = 4, V = 2, PW = $clog2(H*V);
   logic clk = 1'b0, reset, start;
   logic [26:0] init_x, init_y, x_incr, y_incr;
   logic [N-1:0] worker_req, worker_done, assign_valid;
   logic [26:0] assign_cr, assign_ci;
   logic [PW-1:0] assign_addr;
   logic busy, frame_done;
   logic [31:0] frame_cycles;
   int checks = 0, errors = 0;
   int m_state, granted, ptr, m_cycles, exp_addr;
   bit m_fdone;
   logic [N-1:0] m_valid, pend;
   logic [26:0] l_ix, l_iy, l_dx, l_dy, exp_cr, exp_ci;
   int wcnt[N];

   always #5 clk = ~clk;

   mandelbrot_dispatch #(.NUM_WORKERS(N), .H_PIXELS(H), .V_PIXELS(V)) dut (
      .clk(clk), .reset(reset), .start(start),
      .init_x(init_x), .init_y(init_y), .x_incr(x_incr), .y_incr(y_incr),
      .worker_req(worker_req), .worker_done(worker_done),
      .assign_valid(assign_valid), .assign_cr(assign_cr), .assign_ci(assign_ci),
      .assign_addr(assign_addr), .busy(busy), .frame_done(frame_done),
      .frame_cycles(frame_cycles)
   );

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_state = 0; granted = 0; ptr = 0; m_cycles = 0; m_fdone = 0;
      m_valid = '0; pend = '0;
   endtask

   // pixel k: column k%H, row k/H; coordinates follow directly from that
   task automatic model_edge();
      logic [N-1:0] mask;
      if (m_state == 0) begin
         m_valid = '0;
         if (start) begin
            m_state = 1; granted = 0; pend = '0; m_cycles = 0; m_fdone = 0;
            l_ix = init_x; l_iy = init_y; l_dx = x_incr; l_dy = y_incr;
         end
      end else begin
         m_cycles++;
         pend = pend & ~worker_done;
         mask = worker_req & ~m_valid;
         m_valid = '0;
         if (m_state == 1) begin
            for (int i = 0; i < N; i++) begin
               int w;
               w = (ptr + i) % N;
               if (m_valid == '0 && mask[w]) begin
                  m_valid[w] = 1'b1;
                  pend[w] = 1'b1;
                  ptr = (w + 1) % N;
                  exp_addr = granted;
                  exp_cr = l_ix + 27'(granted % H) * l_dx;
                  exp_ci = l_iy + 27'(granted / H) * l_dy;
                  granted++;
                  if (granted == H*V) m_state = 2;
               end
            end
         end else if (pend == '0) begin
            m_state = 0;
            m_fdone = 1;
         end
      end
   endtask

   task automatic compare();
      check("valid", assign_valid, m_valid);
      check("onehot", 32'($countones(assign_valid) <= 1), 1);
      check("busy", busy, m_state != 0);
      check("frame_done", frame_done, m_fdone);
      check("cycles", frame_cycles, m_cycles);
      if (m_valid != '0) begin
         check("addr", assign_addr, exp_addr);
         check("cr", assign_cr, exp_cr);
         check("ci", assign_ci, exp_ci);
      end
   endtask

   // mode 1: only worker 0, fixed latency, no spurious pulses; mode 0: random pool
   task automatic next_inputs(int mode);
      for (int i = 0; i < N; i++) begin
         worker_done[i] = 1'b0;
         if (assign_valid[i]) wcnt[i] = mode == 1 ? 3 : int'($urandom_range(1, 4));
         else if (wcnt[i] > 0) begin
            wcnt[i]--;
            if (wcnt[i] == 0) worker_done[i] = 1'b1;
         end else if (mode == 0 && $urandom_range(0, 19) == 0) worker_done[i] = 1'b1;
         worker_req[i] = wcnt[i] == 0 && (mode == 1 ? i == 0 : $urandom_range(0, 4) != 0);
      end
   endtask

   task automatic step(int mode);
      @(posedge clk);
      model_edge();
      #1;
      compare();
      next_inputs(mode);
   endtask

   task automatic check_reset_outputs();
      check("rst_valid", assign_valid, 0);
      check("rst_cr", assign_cr, 0);
      check("rst_ci", assign_ci, 0);
      check("rst_addr", assign_addr, 0);
      check("rst_busy", busy, 0);
      check("rst_done", frame_done, 0);
      check("rst_cycles", frame_cycles, 0);
   endtask

   task automatic run_frame(int mode, logic [26:0] ix, logic [26:0] iy,
                            logic [26:0] dx, logic [26:0] dy, int inj, int abort);
      init_x = ix; init_y = iy; x_incr = dx; y_incr = dy;
      start = 1'b1;
      step(mode);
      start = 1'b0;
      init_x = $urandom; init_y = $urandom; x_incr = $urandom; y_incr = $urandom;
      for (int c = 0; c < 400 && m_state != 0; c++) begin
         start = c == inj;
         step(mode);
         start = 1'b0;
         if (c == abort) begin
            #3 reset = 1'b1;
            #1 model_reset();
            check_reset_outputs();
            #1 reset = 1'b0;
            return;
         end
      end
      check("end_done", frame_done, 1);
      check("end_busy", busy, 0);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0;
      worker_req = '0; worker_done = '0;
      init_x = '0; init_y = '0; x_incr = '0; y_incr = '0;
      for (int i = 0; i < N; i++) wcnt[i] = 0;
      model_reset();
      #12;
      check_reset_outputs();
      reset = 1'b0;
      run_frame(1, 27'h7000000, 27'h7800000, 27'h0400000, 27'h0400000, -1, -1);
      for (int k = 0; k < 3; k++) step(0);
      run_frame(0, $urandom, $urandom, $urandom, $urandom, 5, -1);
      run_frame(0, 27'h4000000, $urandom, 27'h3FFFFFF, $urandom, -1, -1);
      run_frame(0, $urandom, $urandom, $urandom, $urandom, -1, 4);
      for (int k = 0; k < 8; k++) step(0);
      for (int f = 0; f < 5; f++) begin
         run_frame(0, $urandom, $urandom, $urandom, $urandom, int'($urandom_range(0, 12)), -1);
         for (int k = 0; k < int'($urandom_range(0, 3)); k++) step(0);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
